// File: rtl/conversor_bcd_display_pkg.sv
// Shared definitions for the BCD display output stage: FSM encoding,
// 7-segment constants (active-low {g,f,e,d,c,b,a}) and the double-dabble
// add-3 helper.
package conversor_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // A nibble at or above this value would overflow past 9 when doubled.
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // Double-dabble correction applied to one BCD digit before each shift.
    function automatic logic [3:0] add3_nibble(input logic [3:0] nib);
        if (nib >= ADD3_THRESHOLD) begin
            return nib + 4'd3;
        end else begin
            return nib;
        end
    endfunction

endpackage

// File: rtl/conversor_bcd_display_if.sv
// Bus between the processor's OUT path and the display stage.
interface conversor_bcd_display_if #(
    parameter int WIDTH = 32
);
    logic             ld;
    logic [WIDTH-1:0] valor;
    logic             busy;
    logic             pend;
    logic             done;
    logic [6:0]       display0;
    logic [6:0]       display1;
    logic [6:0]       display2;
    logic [6:0]       display3;
    logic [6:0]       display4;
    logic [6:0]       display5;
    logic [6:0]       display6;
    logic [6:0]       display7;

    modport master (
        output ld, valor,
        input  busy, pend, done,
        input  display0, display1, display2, display3,
        input  display4, display5, display6, display7
    );

    modport slave (
        input  ld, valor,
        output busy, pend, done,
        output display0, display1, display2, display3,
        output display4, display5, display6, display7
    );
endinterface

// File: rtl/conversor_bcd_display_decod_bcd7.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module decod_bcd7
    import conversor_bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Segment lookup for a single digit.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/conversor_bcd_display.sv
// Output stage: sequential double-dabble binary-to-BCD conversion (one bit
// per cycle) feeding eight registered active-low 7-segment displays, with a
// one-deep pending buffer so back-to-back OUT instructions are not lost.
module conversor_bcd_display
    import conversor_bcd_display_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BCD_DIGITS  = 10,
    parameter int BLANK_ZEROS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    conversor_bcd_display_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W = 4 * BCD_DIGITS;

    state_t             state_r;
    logic [WIDTH-1:0]   shift_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   bcd_adj_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   pend_val_r;
    logic               pend_r;
    logic               busy_r;
    logic               done_r;
    logic [6:0]         disp_r   [8];
    logic [6:0]         seg_s    [8];
    logic [6:0]         seg_out_s[8];
    logic               nz_s;

    // Add-3 correction on every BCD nibble in parallel.
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            bcd_adj_s[4*i +: 4] = add3_nibble(bcd_r[4*i +: 4]);
        end
    end

    // Eight digit decoders, one per display.
    for (genvar g = 0; g < 8; g++) begin : g_dec
        decod_bcd7 u_dec (
            .digit (bcd_r[4*g +: 4]),
            .seg   (seg_s[g])
        );
    end

    // Leading-zero blanking: a display blanks when it and all digits above are zero.
    always_comb begin
        nz_s = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            nz_s = nz_s | (bcd_r[4*i +: 4] != 4'd0);
            if ((BLANK_ZEROS != 0) && (i >= 1) && !nz_s) begin
                seg_out_s[i] = SEG_BLANK;
            end else begin
                seg_out_s[i] = seg_s[i];
            end
        end
    end

    // Conversion FSM, datapath, pending buffer and display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            pend_val_r <= '0;
            pend_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                disp_r[i] <= SEG_BLANK;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.ld) begin
                        shift_r <= bus.valor;
                        bcd_r   <= '0;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else if (pend_r) begin
                        shift_r <= pend_val_r;
                        bcd_r   <= '0;
                        cnt_r   <= '0;
                        pend_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[WIDTH-1]};
                    shift_r <= {shift_r[WIDTH-2:0], 1'b0};
                    cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= ST_UPDATE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                    if (bus.ld) begin
                        pend_val_r <= bus.valor;
                        pend_r     <= 1'b1;
                    end else begin
                        pend_r     <= pend_r;
                    end
                end
                ST_UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        disp_r[i] <= seg_out_s[i];
                    end
                    done_r <= 1'b1;
                    if (pend_r) begin
                        shift_r <= pend_val_r;
                        bcd_r   <= '0;
                        cnt_r   <= '0;
                        pend_r  <= 1'b0;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    // A value arriving now waits for the next conversion slot.
                    if (bus.ld) begin
                        pend_val_r <= bus.valor;
                        pend_r     <= 1'b1;
                    end else begin
                        pend_val_r <= pend_val_r;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.pend     = pend_r;
    assign bus.done     = done_r;
    assign bus.display0 = disp_r[0];
    assign bus.display1 = disp_r[1];
    assign bus.display2 = disp_r[2];
    assign bus.display3 = disp_r[3];
    assign bus.display4 = disp_r[4];
    assign bus.display5 = disp_r[5];
    assign bus.display6 = disp_r[6];
    assign bus.display7 = disp_r[7];

endmodule

// File: tb/tb_conversor_bcd_display.sv
// Scoreboard bench: two instances (no blanking / leading-zero blanking) share
// the same stimulus; expected decimal values are queued at stimulus time and
// a monitor checks all displays whenever done pulses.
module tb_conversor_bcd_display;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          ld;
    logic [W-1:0]  valor;

    int n_checks;
    int n_errors;
    int cyc;
    int done_cnt_a;
    int done_cnt_b;
    int busy_tot_a;
    int last_done_cyc_a;
    longint unsigned exp_a[$];
    longint unsigned exp_b[$];

    conversor_bcd_display_if #(.WIDTH(W)) if_a ();
    conversor_bcd_display_if #(.WIDTH(W)) if_b ();

    assign if_a.ld    = ld;
    assign if_a.valor = valor;
    assign if_b.ld    = ld;
    assign if_b.valor = valor;

    conversor_bcd_display #(.WIDTH(W), .BCD_DIGITS(10), .BLANK_ZEROS(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    conversor_bcd_display #(.WIDTH(W), .BCD_DIGITS(10), .BLANK_ZEROS(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    logic [6:0] da [8];
    logic [6:0] db [8];
    assign da[0] = if_a.display0;  assign db[0] = if_b.display0;
    assign da[1] = if_a.display1;  assign db[1] = if_b.display1;
    assign da[2] = if_a.display2;  assign db[2] = if_b.display2;
    assign da[3] = if_a.display3;  assign db[3] = if_b.display3;
    assign da[4] = if_a.display4;  assign db[4] = if_b.display4;
    assign da[5] = if_a.display5;  assign db[5] = if_b.display5;
    assign da[6] = if_a.display6;  assign db[6] = if_b.display6;
    assign da[7] = if_a.display7;  assign db[7] = if_b.display7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input longint unsigned d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference: decimal digit idx of (v mod 10^8), with optional leading-zero blanking.
    function automatic logic [6:0] model_seg(input longint unsigned v, input int idx, input bit blank);
        longint unsigned m;
        longint unsigned p;
        m = v % 64'd100000000;
        p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        if (blank && idx >= 1 && (m / p) == 0) return 7'b1111111;
        return seg_of((m / p) % 10);
    endfunction

    // Monitor: on each done pulse pop the expected value and compare all displays.
    always @(negedge clk) begin
        longint unsigned v;
        if (if_a.busy === 1'b1) busy_tot_a <= busy_tot_a + 1;
        if (if_a.done === 1'b1) begin
            done_cnt_a      <= done_cnt_a + 1;
            last_done_cyc_a <= cyc;
            if (exp_a.size() == 0) begin
                chk("unexpected_done_a", 64'd1, 64'd0);
            end else begin
                v = exp_a.pop_front();
                chk("no_x_a", 64'($isunknown({if_a.display0, if_a.display1, if_a.display2, if_a.display3,
                    if_a.display4, if_a.display5, if_a.display6, if_a.display7, if_a.busy, if_a.pend})), 64'd0);
                for (int i = 0; i < 8; i++)
                    chk($sformatf("disp_a%0d val=%0d", i, v), 64'(da[i]), 64'(model_seg(v, i, 1'b0)));
            end
        end
        if (if_b.done === 1'b1) begin
            done_cnt_b <= done_cnt_b + 1;
            if (exp_b.size() == 0) begin
                chk("unexpected_done_b", 64'd1, 64'd0);
            end else begin
                v = exp_b.pop_front();
                for (int i = 0; i < 8; i++)
                    chk($sformatf("disp_b%0d val=%0d", i, v), 64'(db[i]), 64'(model_seg(v, i, 1'b1)));
            end
        end
    end

    // Assumes caller sits just after a posedge; ld is high for exactly one cycle.
    task automatic pulse_ld(input logic [W-1:0] v);
        ld    = 1'b1;
        valor = v;
        @(posedge clk);
        #1;
        ld    = 1'b0;
    endtask

    task automatic expect_val(input longint unsigned v);
        exp_a.push_back(v);
        exp_b.push_back(v);
    endtask

    task automatic wait_done(input int target, input int budget);
        int c;
        c = 0;
        while (done_cnt_a < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("done_timeout", 64'(done_cnt_a >= target), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int s, d0, b0, dc0, k;
        logic [W-1:0] v, last;
        n_checks = 0; n_errors = 0; cyc = 0;
        done_cnt_a = 0; done_cnt_b = 0; busy_tot_a = 0; last_done_cyc_a = 0;
        ld = 1'b0; valor = '0; reset = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(if_a.busy), 64'd0);
        chk("rst_pend", 64'(if_a.pend), 64'd0);
        chk("rst_done", 64'(if_a.done), 64'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_disp%0d", i), 64'(da[i]), 64'h7f);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // 1: zero, single done pulse.
        d0 = done_cnt_a;
        expect_val(0);
        pulse_ld(0);
        wait_done(d0 + 1, 60);
        idle(5);
        chk("zero_done_once", 64'(done_cnt_a - d0), 64'd1);

        // 2: latency and busy width.
        b0 = busy_tot_a;
        expect_val(12345678);
        pulse_ld(32'd12345678);
        s = cyc;
        wait_done(done_cnt_a + 1, 60);
        chk("latency", 64'(last_done_cyc_a - s), 64'(W + 1));
        idle(3);
        chk("busy_cycles", 64'(busy_tot_a - b0), 64'(W + 1));

        // 3: full-scale value, shows mod 10^8.
        expect_val(64'd4294967295);
        pulse_ld(32'hFFFFFFFF);
        wait_done(done_cnt_a + 1, 60);
        idle(2);

        // 4: back-to-back with pending overwrite; no idle gap between conversions.
        d0 = done_cnt_a;
        expect_val(111);
        expect_val(333);
        pulse_ld(32'd111);
        idle(1);
        pulse_ld(32'd222);
        pulse_ld(32'd333);
        @(negedge clk);
        chk("pend_set", 64'(if_a.pend), 64'd1);
        @(posedge clk); #1;
        wait_done(d0 + 1, 60);
        s = last_done_cyc_a;
        wait_done(d0 + 2, 60);
        chk("chain_spacing", 64'(last_done_cyc_a - s), 64'(W + 1));
        idle(5);
        chk("chain_done_twice", 64'(done_cnt_a - d0), 64'd2);
        chk("pend_clear", 64'(if_a.pend), 64'd0);

        // 5: reset mid-conversion with a pending value, then recover.
        pulse_ld(32'd999);
        pulse_ld(32'd555);
        idle(7);
        dc0 = done_cnt_a;
        reset = 1'b1;
        @(negedge clk);
        exp_a.delete();
        exp_b.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(if_a.busy), 64'd0);
        chk("midrst_pend", 64'(if_a.pend), 64'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("midrst_disp%0d", i), 64'(da[i]), 64'h7f);
        @(posedge clk); #1;
        idle(40);
        chk("midrst_no_done", 64'(done_cnt_a - dc0), 64'd0);
        expect_val(7);
        pulse_ld(32'd7);
        wait_done(done_cnt_a + 1, 60);
        idle(2);

        // 6: blanking case (instance b) via the common path.
        expect_val(105);
        pulse_ld(32'd105);
        wait_done(done_cnt_a + 1, 60);
        idle(2);

        // Randomized: optional burst of overlapping loads inside the shift window.
        for (int it = 0; it < 25; it++) begin
            d0 = done_cnt_a;
            v = $urandom() >> $urandom_range(0, 31);
            expect_val(v);
            pulse_ld(v);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                idle($urandom_range(0, 5));
                last = $urandom() >> $urandom_range(0, 31);
                pulse_ld(last);
            end
            if (k > 0) expect_val(last);
            wait_done(d0 + ((k > 0) ? 2 : 1), 120);
            idle($urandom_range(1, 4));
        end

        idle(5);
        chk("a_queue_empty", 64'(exp_a.size()), 64'd0);
        chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
        chk("ab_done_match", 64'(done_cnt_b), 64'(done_cnt_a));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
